// File: rtl/project_pwm_pkg.sv
// Shared PWM definitions: counting modes, follower FSM state encoding, default width.
package project_pwm_pkg;

    localparam int W_DEFAULT = 16;

    localparam logic [1:0] MODE_OFF     = 2'b00;
    localparam logic [1:0] MODE_UP      = 2'b01;
    localparam logic [1:0] MODE_DOWN    = 2'b10;
    localparam logic [1:0] MODE_UP_DOWN = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

endpackage

// File: rtl/project_period_count_step.sv
// One free-running count step (mode, count, direction, period) -> (next count, next direction).
// Shared by the period counter master and slave; direction 0 = up, 1 = down.
module project_period_count_step
    import project_pwm_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic [1:0]   mode,
    input  logic [W-1:0] count,
    input  logic         dir,
    input  logic [W-1:0] period,
    output logic [W-1:0] count_next,
    output logic         dir_next
);

    logic turn_dir;

    always_comb begin
        count_next = count;
        dir_next   = dir;
        turn_dir   = dir;
        case (mode)
            MODE_UP: begin
                count_next = (count >= period) ? '0 : count + 1'b1;
            end
            MODE_DOWN: begin
                count_next = (count == '0 || count > period) ? period : count - 1'b1;
            end
            MODE_UP_DOWN: begin
                // turn around on the end points before stepping
                if (count >= period)
                    turn_dir = 1'b1;
                else if (count == '0)
                    turn_dir = 1'b0;
                else
                    turn_dir = dir;
                if (period == '0)
                    count_next = '0;
                else
                    count_next = turn_dir ? count - 1'b1 : count + 1'b1;
                dir_next = turn_dir;
            end
            default: begin
                count_next = count;
            end
        endcase
    end

endmodule

// File: rtl/project_period_counter_slave.sv
// Follower period counter: free count, phase realignment on accepted sync, lock tracking.
// Optional sync-loss watchdog enabled by defining PERIOD_SLAVE_SYNC_WATCHDOG_EN.
//
// state      | meaning
// IDLE       | mode OFF or sync disabled; free count only
// ACQUIRE    | free count, waiting for the first accepted sync
// LOCKED     | aligned to upstream; each sync checked against the free count
module project_period_counter_slave
    import project_pwm_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic         i_clk,
    input  logic         i_reset_n,
    input  logic         i_en,
    input  logic         i_sync_en,
    input  logic         i_sync,
    input  logic [1:0]   i_mode,
    input  logic [W-1:0] i_period,
    input  logic [W-1:0] i_phase,
    input  logic         i_phase_dir,
    output logic [W-1:0] o_period,
    output logic [W-1:0] o_period_next,
    output logic         o_sync,
    output logic         o_locked,
    output logic         o_resync,
    output logic         o_sync_lost
);

    state_t         state;
    logic [W-1:0]   count;
    logic           dir;
    logic [W-1:0]   free_next;
    logic           free_dir_next;
    logic [W-1:0]   phase_clamp;
    logic           load_dir;
    logic           accept;

    project_period_count_step #(.W(W)) u_step (
        .mode       (i_mode),
        .count      (count),
        .dir        (dir),
        .period     (i_period),
        .count_next (free_next),
        .dir_next   (free_dir_next)
    );

    assign accept      = i_en & i_sync_en & i_sync & (i_mode != MODE_OFF);
    assign phase_clamp = (i_phase > i_period) ? i_period : i_phase;

    // a phase landing on an end point must already be heading back inward
    always_comb begin
        load_dir = free_dir_next;
        if (i_mode == MODE_UP_DOWN) begin
            if (phase_clamp == i_period)
                load_dir = 1'b1;
            else if (phase_clamp == '0)
                load_dir = 1'b0;
            else
                load_dir = i_phase_dir;
        end
    end

    assign o_period_next = !i_en ? count : (accept ? phase_clamp : free_next);
    assign o_period      = count;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            count  <= '0;
            dir    <= 1'b0;
            o_sync <= 1'b0;
        end else if (i_en) begin
            count  <= o_period_next;
            dir    <= accept ? load_dir : free_dir_next;
            o_sync <= i_sync_en & (o_period_next == i_period);
        end
    end

`ifdef PERIOD_SLAVE_SYNC_WATCHDOG_EN
    logic [W+1:0] wd_count;
    logic [W+1:0] wd_inc;
    logic [W+1:0] wd_limit;

    assign wd_inc   = wd_count + 1'b1;
    assign wd_limit = {1'b0, i_period, 1'b0} + (W+2)'(2);
`else
    assign o_sync_lost = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state    <= ST_ACQUIRE;
            o_locked <= 1'b0;
            o_resync <= 1'b0;
`ifdef PERIOD_SLAVE_SYNC_WATCHDOG_EN
            o_sync_lost <= 1'b0;
            wd_count    <= '0;
`endif
        end else if (i_en) begin
            o_resync <= 1'b0;
`ifdef PERIOD_SLAVE_SYNC_WATCHDOG_EN
            o_sync_lost <= 1'b0;
            wd_count    <= '0;
`endif
            if (i_mode == MODE_OFF || !i_sync_en) begin
                state    <= ST_IDLE;
                o_locked <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state <= ST_ACQUIRE;
                    end
                    ST_ACQUIRE: begin
                        if (accept) begin
                            state    <= ST_LOCKED;
                            o_locked <= 1'b1;
                        end
                    end
                    ST_LOCKED: begin
                        if (accept) begin
                            o_resync <= (free_next != phase_clamp);
                        end
`ifdef PERIOD_SLAVE_SYNC_WATCHDOG_EN
                        else if (wd_inc > wd_limit) begin
                            state       <= ST_ACQUIRE;
                            o_locked    <= 1'b0;
                            o_sync_lost <= 1'b1;
                        end else begin
                            wd_count <= wd_inc;
                        end
`endif
                    end
                    default: begin
                        state    <= ST_IDLE;
                        o_locked <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_project_period_counter_slave.sv
// Directed bench for the follower period counter; expected values are hand-computed.
module tb_project_period_counter_slave;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b1;
    logic         sync_en = 1'b1;
    logic         sync = 1'b0;
    logic [1:0]   mode = 2'b01;
    logic [W-1:0] period = 16'd4;
    logic [W-1:0] phase = 16'd0;
    logic         phase_dir = 1'b0;

    logic [W-1:0] o_period;
    logic [W-1:0] o_period_next;
    logic         o_sync;
    logic         o_locked;
    logic         o_resync;
    logic         o_sync_lost;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    project_period_counter_slave #(.W(W)) dut (
        .i_clk         (clk),
        .i_reset_n     (rst_n),
        .i_en          (en),
        .i_sync_en     (sync_en),
        .i_sync        (sync),
        .i_mode        (mode),
        .i_period      (period),
        .i_phase       (phase),
        .i_phase_dir   (phase_dir),
        .o_period      (o_period),
        .o_period_next (o_period_next),
        .o_sync        (o_sync),
        .o_locked      (o_locked),
        .o_resync      (o_resync),
        .o_sync_lost   (o_sync_lost)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        n_cmp++;
        if ({o_period, o_sync, o_locked, o_resync, o_sync_lost} !== {16'd0, 4'b0000}) begin
            n_err++;
            $display("FAIL reset: got period=%0d sync=%b locked=%b resync=%b lost=%b, want 0 0 0 0 0",
                     o_period, o_sync, o_locked, o_resync, o_sync_lost);
        end
    endtask

    task automatic test_up_free();
        logic [W-1:0] exp_seq [6];
        exp_seq = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd0, 16'd1};
        for (int i = 0; i < 6; i++) begin
            tick();
            n_cmp++;
            if (o_period !== exp_seq[i] || o_sync !== (exp_seq[i] == 16'd4) || o_locked !== 1'b0) begin
                n_err++;
                $display("FAIL up_free[%0d]: got period=%0d sync=%b locked=%b, want %0d %b 0",
                         i, o_period, o_sync, o_locked, exp_seq[i], (exp_seq[i] == 16'd4));
            end
        end
    endtask

    task automatic test_sync_lock();
        int k;
        period = 16'd9;
        k = 0;
        while (o_period !== 16'd6 && k < 20) begin tick(); k++; end
        n_cmp++;
        if (o_period !== 16'd6) begin
            n_err++;
            $display("FAIL wait6: got period=%0d, want 6", o_period);
        end
        sync = 1'b1; phase = 16'd0;
        #1;
        n_cmp++;
        if (o_period_next !== 16'd0) begin
            n_err++;
            $display("FAIL next_comb: got %0d, want 0", o_period_next);
        end
        tick();
        sync = 1'b0;
        n_cmp++;
        if (o_period !== 16'd0 || o_locked !== 1'b1 || o_resync !== 1'b0) begin
            n_err++;
            $display("FAIL lock: got period=%0d locked=%b resync=%b, want 0 1 0", o_period, o_locked, o_resync);
        end
        k = 0;
        while (o_period !== 16'd9 && k < 20) begin tick(); k++; end
        n_cmp++;
        if (k !== 9) begin
            n_err++;
            $display("FAIL wait9: got %0d cycles, want 9", k);
        end
        sync = 1'b1;
        tick();
        sync = 1'b0;
        n_cmp++;
        if (o_period !== 16'd0 || o_locked !== 1'b1 || o_resync !== 1'b0) begin
            n_err++;
            $display("FAIL match_sync: got period=%0d locked=%b resync=%b, want 0 1 0", o_period, o_locked, o_resync);
        end
    endtask

    task automatic test_resync();
        tick();
        tick();
        sync = 1'b1; phase = 16'd0;
        tick();
        sync = 1'b0;
        n_cmp++;
        if (o_period !== 16'd0 || o_resync !== 1'b1 || o_locked !== 1'b1) begin
            n_err++;
            $display("FAIL resync: got period=%0d resync=%b locked=%b, want 0 1 1", o_period, o_resync, o_locked);
        end
        tick();
        n_cmp++;
        if (o_period !== 16'd1 || o_resync !== 1'b0) begin
            n_err++;
            $display("FAIL resync_clear: got period=%0d resync=%b, want 1 0", o_period, o_resync);
        end
    endtask

    task automatic test_up_down();
        logic [W-1:0] exp_seq [8];
        exp_seq = '{16'd2, 16'd1, 16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd3};
        mode = 2'b11; period = 16'd4;
        sync = 1'b1; phase = 16'd2; phase_dir = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            sync = 1'b0;
            n_cmp++;
            if (o_period !== exp_seq[i]) begin
                n_err++;
                $display("FAIL updown[%0d]: got %0d, want %0d", i, o_period, exp_seq[i]);
            end
        end
        sync = 1'b1; phase = 16'd7; phase_dir = 1'b0;
        tick();
        sync = 1'b0;
        n_cmp++;
        if (o_period !== 16'd4 || o_resync !== 1'b1 || o_sync !== 1'b1) begin
            n_err++;
            $display("FAIL clamp: got period=%0d resync=%b sync=%b, want 4 1 1", o_period, o_resync, o_sync);
        end
        tick();
        n_cmp++;
        if (o_period !== 16'd3) begin
            n_err++;
            $display("FAIL clamp_down1: got %0d, want 3", o_period);
        end
        tick();
        n_cmp++;
        if (o_period !== 16'd2) begin
            n_err++;
            $display("FAIL clamp_down2: got %0d, want 2", o_period);
        end
    endtask

    task automatic test_enable_reset();
        int k;
        sync = 1'b1; phase = 16'd0;
        tick();
        en = 1'b0; phase = 16'd3;
        tick();
        tick();
        n_cmp++;
        if (o_period !== 16'd0 || o_resync !== 1'b1 || o_locked !== 1'b1) begin
            n_err++;
            $display("FAIL freeze: got period=%0d resync=%b locked=%b, want 0 1 1", o_period, o_resync, o_locked);
        end
        en = 1'b1; sync = 1'b0;
        tick();
        n_cmp++;
        if (o_period !== 16'd1 || o_resync !== 1'b0) begin
            n_err++;
            $display("FAIL unfreeze: got period=%0d resync=%b, want 1 0", o_period, o_resync);
        end
        k = 0;
        while (o_period !== 16'd4 && k < 20) begin tick(); k++; end
        n_cmp++;
        if (o_period !== 16'd4 || o_sync !== 1'b1 || o_locked !== 1'b1) begin
            n_err++;
            $display("FAIL at_top: got period=%0d sync=%b locked=%b, want 4 1 1", o_period, o_sync, o_locked);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({o_period, o_sync, o_locked, o_resync, o_sync_lost} !== {16'd0, 4'b0000}) begin
            n_err++;
            $display("FAIL async_reset: got period=%0d sync=%b locked=%b resync=%b lost=%b, want 0 0 0 0 0",
                     o_period, o_sync, o_locked, o_resync, o_sync_lost);
        end
        @(posedge clk);
        #2 rst_n = 1'b1;
        tick();
        n_cmp++;
        if (o_period !== 16'd1) begin
            n_err++;
            $display("FAIL resume: got %0d, want 1", o_period);
        end
    endtask

    task automatic test_idle();
        sync = 1'b1; phase = 16'd0;
        tick();
        sync = 1'b0;
        sync_en = 1'b0;
        tick();
        n_cmp++;
        if (o_locked !== 1'b0) begin
            n_err++;
            $display("FAIL idle: got locked=%b, want 0", o_locked);
        end
    endtask

    task automatic test_watchdog();
        int first_k;
        logic locked_at;
        mode = 2'b01; period = 16'd4; sync_en = 1'b1;
        tick();
        sync = 1'b1; phase = 16'd0;
        tick();
        sync = 1'b0;
        first_k = -1;
        locked_at = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (o_sync_lost === 1'b1 && first_k < 0) begin
                first_k = k;
                locked_at = o_locked;
            end
        end
`ifdef PERIOD_SLAVE_SYNC_WATCHDOG_EN
        n_cmp++;
        if (first_k !== 11 || locked_at !== 1'b0) begin
            n_err++;
            $display("FAIL watchdog: got pulse at %0d locked=%b, want 11 0", first_k, locked_at);
        end
`else
        n_cmp++;
        if (first_k !== -1 || o_locked !== 1'b1) begin
            n_err++;
            $display("FAIL no_watchdog: got pulse at %0d locked=%b, want -1 1", first_k, o_locked);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_up_free();
        test_sync_lock();
        test_resync();
        test_up_down();
        test_enable_reset();
        test_idle();
        test_watchdog();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
